// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: pixel RAM with command/handshake front end, wrapping bursts and post-reset clear
module ram_burst_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err
);
    localparam logic [1:0] CLEAR = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] READ  = 2'd3;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr, addr, next_addr;
    logic [LEN_W-1:0]  len, cnt;
    logic              accept, bad, beat, last;
    logic [DATA_W-1:0] mem [DEPTH];

    // handshakes and address stepping; the address wraps at DEPTH, not at 2**ADDR_W
    always_comb begin
        cmd_ready = state == IDLE;
        wr_ready  = state == WRITE;
        busy      = state != IDLE;
        accept    = cmd_valid && cmd_ready;
        bad       = {1'b0, cmd_addr} >= LIMIT;
        beat      = wr_valid && wr_ready;
        last      = cnt == len;
        next_addr = addr == LAST ? '0 : addr + 1'b1;
    end

    // single write port: clear sweep or accepted write beat
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[ptr] <= '0;
        else if (beat)
            mem[addr] <= wr_data;
    end

    // control FSM, registered read data and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            ptr      <= '0;
            addr     <= '0;
            len      <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            err      <= 1'b0;
        end else begin
            err      <= accept && bad;
            rd_valid <= state == READ;
            case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST)
                        state <= IDLE;
                end
                IDLE: begin
                    if (accept && !bad) begin
                        addr  <= cmd_addr;
                        len   <= cmd_len;
                        cnt   <= '0;
                        state <= cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (beat) begin
                        addr <= next_addr;
                        cnt  <= cnt + 1'b1;
                        if (last)
                            state <= IDLE;
                    end
                end
                default: begin
                    rd_data <= mem[addr];
                    addr    <= next_addr;
                    cnt     <= cnt + 1'b1;
                    if (last)
                        state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: randomized bursts on 256- and 200-word instances against an array model
module tb_ram_burst_ctrl;
    logic        clk = 0;
    logic        rst [2];
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic        cmd_write [2];
    logic [7:0]  cmd_addr [2];
    logic [3:0]  cmd_len [2];
    logic        wr_valid [2];
    logic        wr_ready [2];
    logic [15:0] wr_data [2];
    logic        rd_valid [2];
    logic [15:0] rd_data [2];
    logic        busy [2];
    logic        err [2];

    int          checks = 0;
    int          errors = 0;
    int          dep [2] = '{256, 200};
    logic [15:0] m [2][256];
    logic [15:0] wq [$];

    always #5 clk = ~clk;

    ram_burst_ctrl #(.DEPTH(256)) u_d0 (
        .clk(clk), .reset(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_len(cmd_len[0]),
        .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_data(wr_data[0]),
        .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .busy(busy[0]), .err(err[0])
    );

    ram_burst_ctrl #(.DEPTH(200)) u_d1 (
        .clk(clk), .reset(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_len(cmd_len[1]),
        .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_data(wr_data[1]),
        .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .busy(busy[1]), .err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d, input bit wait_clear);
        int n;
        rst[d] = 1;
        tick();
        rst[d] = 0;
        for (int i = 0; i < dep[d]; i++) m[d][i] = 16'h0;
        chk("rst_busy", busy[d], 1);
        chk("rst_cmd_ready", cmd_ready[d], 0);
        chk("rst_wr_ready", wr_ready[d], 0);
        chk("rst_rd_valid", rd_valid[d], 0);
        chk("rst_rd_data", rd_data[d], 0);
        chk("rst_err", err[d], 0);
        if (wait_clear) begin
            n = 0;
            while (!cmd_ready[d] && n < dep[d] + 8) begin
                tick();
                n++;
            end
            chk("clear_cycles", n, dep[d]);
            chk("idle_busy", busy[d], 0);
        end
    endtask

    task automatic issue(input int d, input int wr, input int a, input int len,
                         output int waited, output bit ok);
        cmd_valid[d] = 1;
        cmd_write[d] = wr[0];
        cmd_addr[d]  = 8'(a);
        cmd_len[d]   = 4'(len);
        waited = 0;
        while (!cmd_ready[d] && waited < 400) begin
            tick();
            waited++;
        end
        ok = cmd_ready[d];
        if (!ok) chk("cmd_timeout", 0, 1);
        else tick();
        cmd_valid[d] = 0;
        cmd_addr[d]  = 8'($urandom);
    endtask

    task automatic burst(input int d, input int wr, input int a0, input int len,
                         input logic [31:0] mask, output int waited);
        bit          ok;
        int          a, k, cyc;
        logic [15:0] dat, lastd;
        issue(d, wr, a0, len, waited, ok);
        if (!ok) return;
        if (a0 >= dep[d]) begin
            chk("err_pulse", err[d], 1);
            tick();
            chk("err_clear", err[d], 0);
            chk("err_idle", cmd_ready[d], 1);
            return;
        end
        chk("no_err", err[d], 0);
        a = a0;
        if (wr != 0) begin
            k = 0;
            cyc = 0;
            while (k <= len && cyc < 80) begin
                chk("wr_ready", wr_ready[d], 1);
                dat = (wq.size() > 0) ? wq[0] : 16'($urandom);
                wr_valid[d] = (cyc < 32) ? !mask[cyc] : 1'b1;
                wr_data[d] = dat;
                @(posedge clk);
                if (wr_valid[d]) begin
                    if (wq.size() > 0) void'(wq.pop_front());
                    m[d][a] = dat;
                    a = (a + 1) % dep[d];
                    k++;
                end
                #1;
                wr_valid[d] = 0;
                wr_data[d] = 16'($urandom);
                cyc++;
            end
            chk("wr_beats", k, len + 1);
            chk("wr_done_ready", wr_ready[d], 0);
            chk("wr_done_busy", busy[d], 0);
        end else begin
            lastd = 0;
            for (int i = 0; i <= len; i++) begin
                tick();
                chk("rd_valid", rd_valid[d], 1);
                chk("rd_data", rd_data[d], m[d][a]);
                lastd = m[d][a];
                a = (a + 1) % dep[d];
            end
            chk("rd_last_idle", busy[d], 0);
            tick();
            chk("rd_valid_drop", rd_valid[d], 0);
            chk("rd_data_hold", rd_data[d], lastd);
        end
    endtask

    initial begin
        int w;
        bit ok;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1; cmd_valid[d] = 0; cmd_write[d] = 0; cmd_addr[d] = 0;
            cmd_len[d] = 0; wr_valid[d] = 0; wr_data[d] = 0;
        end
        tick();
        do_reset(0, 1);
        do_reset(1, 1);

        burst(0, 0, 0, 15, 0, w);

        wq.push_back(16'h00C0);
        burst(0, 1, 8'h01, 0, 0, w);
        burst(0, 0, 8'h01, 0, 0, w);

        wq.push_back(16'h00A1); wq.push_back(16'h00A2);
        wq.push_back(16'h00A3); wq.push_back(16'h00A4);
        burst(0, 1, 8'hFE, 3, 0, w);
        chk("wrap_mem00", m[0][0], 16'h00A3);
        burst(0, 0, 8'hFE, 3, 0, w);

        burst(0, 1, 8'h40, 3, 32'b1010, w);
        burst(0, 0, 8'h40, 3, 0, w);

        burst(1, 1, 8'hC8, 0, 0, w);
        burst(1, 1, 8'hC7, 1, 0, w);
        burst(1, 0, 8'hC7, 1, 0, w);
        burst(1, 0, 8'h00, 0, 0, w);

        repeat (40) begin
            for (int d = 0; d < 2; d++)
                burst(d, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 15)), $urandom, w);
        end

        issue(0, 0, 0, 7, w, ok);
        for (int i = 0; i < 3 && ok; i++) begin
            tick();
            chk("abort_rd_valid", rd_valid[0], 1);
            chk("abort_rd_data", rd_data[0], m[0][i]);
        end
        do_reset(0, 0);
        burst(0, 0, 8'h01, 0, 0, w);
        chk("held_cmd_wait", w, 256);
        burst(0, 0, 8'hFE, 3, 0, w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
